// File: rtl/conv_pkg.sv
// Shared types for the convolutional SNN layer.
//   arbiter_mode_t : feature-map arbiter source select (convolution or pooling)
//   layer_phase_t  : phase of the layer scheduler, also exported for debug
//   is_guarded_phase(): phases that are covered by the watchdog
package conv_pkg;

    typedef enum logic {
        MUX_CONVOLUTION = 1'b0,
        MUX_POOLING     = 1'b1
    } arbiter_mode_t;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CONVOLUTION = 3'd1,
        DRAIN       = 3'd2,
        SWITCH      = 3'd3,
        POOLING     = 3'd4,
        PAUSE       = 3'd5
    } layer_phase_t;

    // Every phase between leaving convolution and returning to it can hang
    // on an external engine, so all of them are watched.
    function automatic logic is_guarded_phase(input layer_phase_t p);
        return (p == DRAIN) || (p == SWITCH) || (p == POOLING) || (p == PAUSE);
    endfunction

endpackage

// File: rtl/layer_watchdog.sv
// Phase watchdog counter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the counter (highest priority)
//   load       : start a new guarded span; the entry cycle counts as cycle 1
//   count_en   : count one more cycle, saturating at WATCHDOG_CYCLES
//   expired    : terminal count reached
// WATCHDOG_CYCLES = 0 removes the counter; expired is tied low.
module layer_watchdog #(
    parameter int WATCHDOG_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    generate
        if (WATCHDOG_CYCLES > 0) begin : g_wd
            localparam int CW = $clog2(WATCHDOG_CYCLES + 1);
            localparam logic [CW-1:0] TERMINAL = CW'(WATCHDOG_CYCLES);

            logic [CW-1:0] count_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (load) begin
                    count_reg <= CW'(1);
                end else if (count_en && (count_reg != TERMINAL)) begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            assign expired = (count_reg == TERMINAL);
        end else begin : g_off
            logic unused_wd_inputs;
            assign unused_wd_inputs = ^{clk, reset, clear, load, count_en};
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/conv_layer_scheduler.sv
// Phase sequencer for one convolutional SNN layer.
// Alternates event-driven convolution with a sum-pooling/fire pass every
// POOL_INTERVAL timesteps, drives the feature-map arbiter mode, gates the
// convolution engine, stalls pooling on output-FIFO backpressure and
// guards the non-convolution phases with a watchdog.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   enable               : layer run permission
//   timestep_event       : pulse, a timestep marker was consumed
//   conv_active          : convolution engine busy
//   conv_enable          : convolution engine may consume events
//   pool_start           : one-cycle pooling start pulse
//   pool_active          : pooling engine busy (monitor only)
//   pool_done            : pulse, pooling pass complete
//   out_fifo_full_next   : output FIFO about to fill
//   pool_stall           : pooling must hold its writes
//   arbiter_mode         : arbiter source select
//   timestep_count       : timesteps since reset, wrapping
//   phase                : current state (debug)
//   watchdog_error       : sticky watchdog flag
// All outputs are registered; they are computed from the next state.
module conv_layer_scheduler
    import conv_pkg::*;
#(
    parameter int POOL_INTERVAL        = 1,
    parameter int TS_COUNT_WIDTH       = 16,
    parameter int SWITCH_SETTLE_CYCLES = 1,
    parameter int WATCHDOG_CYCLES      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      timestep_event,
    input  logic                      conv_active,
    output logic                      conv_enable,
    output logic                      pool_start,
    input  logic                      pool_active,
    input  logic                      pool_done,
    input  logic                      out_fifo_full_next,
    output logic                      pool_stall,
    output arbiter_mode_t             arbiter_mode,
    output logic [TS_COUNT_WIDTH-1:0] timestep_count,
    output layer_phase_t              phase,
    output logic                      watchdog_error
);

    localparam int IW = $clog2(POOL_INTERVAL + 1);
    localparam int SW = $clog2(SWITCH_SETTLE_CYCLES + 1);
    localparam logic [IW:0]   INTERVAL_WIDE = (IW + 1)'(POOL_INTERVAL);
    localparam logic [IW-1:0] INTERVAL_SAT  = IW'(POOL_INTERVAL);

    layer_phase_t              state_reg, state_next;
    logic [IW-1:0]             interval_reg, interval_next;
    logic [SW-1:0]             settle_reg, settle_next;
    logic                      conv_enable_reg;
    logic                      pool_start_reg;
    logic                      pool_stall_reg;
    arbiter_mode_t             arbiter_mode_reg;
    logic [TS_COUNT_WIDTH-1:0] timestep_count_reg;
    logic                      watchdog_error_reg;

    logic [IW:0] interval_sum;
    logic        interval_full;
    logic        wd_expired;
    logic        wd_trip;

    logic unused_pool_active;
    assign unused_pool_active = pool_active;

    // Interval accumulation happens in every state; outside convolution it
    // saturates so a pending pass is remembered for back-to-back pooling.
    assign interval_sum  = {1'b0, interval_reg} + (IW + 1)'(timestep_event);
    assign interval_full = (interval_sum >= INTERVAL_WIDE);
    assign wd_trip       = wd_expired && is_guarded_phase(state_reg);

    always_comb begin
        state_next    = state_reg;
        settle_next   = settle_reg;
        interval_next = interval_full ? INTERVAL_SAT : interval_sum[IW-1:0];

        case (state_reg)
            IDLE: begin
                if (enable && !watchdog_error_reg) begin
                    state_next = CONVOLUTION;
                end
            end
            CONVOLUTION: begin
                // With enable low the pass is deferred, not dropped.
                if (enable && interval_full) begin
                    interval_next = '0;
                    state_next    = DRAIN;
                end
            end
            DRAIN: begin
                if (!conv_active) begin
                    settle_next = SW'(SWITCH_SETTLE_CYCLES);
                    state_next  = SWITCH;
                end
            end
            SWITCH: begin
                if (settle_reg <= SW'(1)) begin
                    settle_next = '0;
                    state_next  = POOLING;
                end else begin
                    settle_next = settle_reg - SW'(1);
                end
            end
            POOLING: begin
                if (pool_done) begin
                    state_next = CONVOLUTION;
                end else if (out_fifo_full_next) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (pool_done) begin
                    state_next = CONVOLUTION;
                end else if (!out_fifo_full_next) begin
                    state_next = POOLING;
                end
            end
            default: state_next = IDLE;
        endcase

        if (wd_trip) begin
            state_next = IDLE;
        end
    end

    layer_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!is_guarded_phase(state_next)),
        .load    (is_guarded_phase(state_next) && !is_guarded_phase(state_reg)),
        .count_en(is_guarded_phase(state_reg)),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            interval_reg       <= '0;
            settle_reg         <= '0;
            conv_enable_reg    <= 1'b0;
            pool_start_reg     <= 1'b0;
            pool_stall_reg     <= 1'b0;
            arbiter_mode_reg   <= MUX_CONVOLUTION;
            timestep_count_reg <= '0;
            watchdog_error_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            interval_reg       <= interval_next;
            settle_reg         <= settle_next;
            conv_enable_reg    <= (state_next == CONVOLUTION) && enable;
            pool_start_reg     <= (state_reg == SWITCH) && (state_next == POOLING);
            pool_stall_reg     <= (state_next == PAUSE);
            arbiter_mode_reg   <= ((state_next == SWITCH) || (state_next == POOLING) ||
                                   (state_next == PAUSE)) ? MUX_POOLING : MUX_CONVOLUTION;
            timestep_count_reg <= timestep_count_reg + TS_COUNT_WIDTH'(timestep_event);
            watchdog_error_reg <= watchdog_error_reg || wd_trip;
        end
    end

    assign conv_enable    = conv_enable_reg;
    assign pool_start     = pool_start_reg;
    assign pool_stall     = pool_stall_reg;
    assign arbiter_mode   = arbiter_mode_reg;
    assign timestep_count = timestep_count_reg;
    assign phase          = state_reg;
    assign watchdog_error = watchdog_error_reg;

endmodule
